// File: rtl/pipeline_subtractor.sv
// Three-stage pipelined unsigned subtractor: capture, low-half subtract, high-half subtract.
// The low-half borrow crosses one register boundary into the high-half stage.
module pipeline_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic [7:0]       result_cnt
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] a1, b1;
    logic             v1;
    logic [H-1:0]     dl2, a2_hi, b2_hi;
    logic             bl2;
    logic             v2;

    logic [H:0]       low_sub;
    logic [H:0]       high_sub;

    // Borrow is the MSB of each H+1-bit half result.
    always_comb begin
        low_sub  = {1'b0, a1[H-1:0]} - {1'b0, b1[H-1:0]};
        high_sub = {1'b0, a2_hi} - {1'b0, b2_hi} - {{H{1'b0}}, bl2};
    end

    assign busy = v1 | v2 | out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1         <= '0;
            b1         <= '0;
            v1         <= 1'b0;
            dl2        <= '0;
            bl2        <= 1'b0;
            a2_hi      <= '0;
            b2_hi      <= '0;
            v2         <= 1'b0;
            diff       <= '0;
            bout       <= 1'b0;
            out_valid  <= 1'b0;
            result_cnt <= '0;
        end else if (flush) begin
            // Flush outranks stall; the delivered-result count survives it.
            a1        <= '0;
            b1        <= '0;
            v1        <= 1'b0;
            dl2       <= '0;
            bl2       <= 1'b0;
            a2_hi     <= '0;
            b2_hi     <= '0;
            v2        <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            a1        <= a;
            b1        <= b;
            v1        <= in_valid;
            dl2       <= low_sub[H-1:0];
            bl2       <= low_sub[H];
            a2_hi     <= a1[WIDTH-1:H];
            b2_hi     <= b1[WIDTH-1:H];
            v2        <= v1;
            diff      <= {high_sub[H-1:0], dl2};
            bout      <= high_sub[H];
            out_valid <= v2;
            if (v2) begin
                result_cnt <= result_cnt + 8'd1;
            end
        end
    end

endmodule
